udma_crc_seq: RTL and testbench
===============================

UDMA_CRC_SEQ -- requirements
Module: udma_crc_seq

Interface
REQ-001 Parameter: CNT_W, 16, width of burst word counter.
REQ-002 Port: CLK4  input  1  system clock; all logic rises on posedge CLK4.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: BURST_START  input  1  one-cycle pulse, UDMA burst begins.
REQ-005 Port: BURST_STOP  input  1  one-cycle pulse, burst data phase terminated.
REQ-006 Port: ABORT  input  1  one-cycle pulse, cancel burst unconditionally.
REQ-007 Port: WORD_STB  input  1  one-cycle pulse, D holds a valid transferred word.
REQ-008 Port: HCRC_STB  input  1  one-cycle pulse, D holds the host-sent CRC word.
REQ-009 Port: D  input  16  data bus (transfer words and host CRC).
REQ-010 Port: BUSY  output  1  high from accepted BURST_START until return to IDLE.
REQ-011 Port: CRC_OUT  output  16  CRC latched at burst termination.
REQ-012 Port: CRC_VALID  output  1  one-cycle pulse when CRC_OUT updates.
REQ-013 Port: CRC_ERR  output  1  sticky host/device CRC mismatch flag.
REQ-014 Port: WORD_CNT  output  CNT_W  words accumulated in current burst (macro-dependent, REQ-031).

Function
REQ-015 FSM states SHALL be IDLE, XFER, TERM, CHECK, DONE.
REQ-016 IDLE: internal CRC_ARM=0 (CRC register preset 16'h4ABA); BURST_START -> XFER, CRC_ARM=1 from next cycle.
REQ-017 XFER: CRC_ENB = WORD_STB (combinational, same cycle); D fed to CRC core unmodified; CRC register updates on the following edge.
REQ-018 WORD_STB outside XFER SHALL be ignored (CRC_ENB=0); BURST_START outside IDLE ignored.
REQ-019 XFER: BURST_STOP -> TERM; WORD_STB in same cycle as BURST_STOP SHALL be included in the CRC.
REQ-020 TERM (1 cycle): CRC_OUT <= CRC core output; CRC_VALID=1 on the cycle after TERM; -> CHECK.
REQ-021 CHECK: wait for HCRC_STB; on it CRC_ERR <= CRC_ERR | (D != CRC_OUT); -> DONE.
REQ-022 DONE (1 cycle): BUSY=0 next cycle; -> IDLE; CRC_ARM returns 0.
REQ-023 CRC_ERR SHALL clear only on accepted BURST_START or RST; CRC_OUT holds until next TERM.
REQ-024 ABORT in any non-IDLE state -> IDLE next cycle; no CRC_VALID, CRC_OUT and CRC_ERR unchanged; ABORT wins over any simultaneous pulse.
REQ-025 HCRC_STB outside CHECK SHALL be ignored; zero-word burst yields CRC_OUT=16'h4ABA.
REQ-026 BUSY SHALL be high in XFER, TERM, CHECK, DONE.

Reset
REQ-027 RST SHALL force IDLE, CRC_ARM=0, CRC_OUT=16'h0000, CRC_VALID=0, CRC_ERR=0, WORD_CNT=0, BUSY=0, within one CLK4 edge.
REQ-028 RST mid-burst SHALL discard the burst; RST has priority over all inputs.

Configuration
REQ-029 Macro UDMA_CRC_WORD_COUNT_EN selects word counting.
REQ-030 Defined: WORD_CNT clears on accepted BURST_START, increments per accepted WORD_STB, wraps from all-ones to 0, holds after BURST_STOP.
REQ-031 Undefined: no counter logic; WORD_CNT tied to 0.

Structure
REQ-032 Shared package: FSM state encoding, CRC preset 16'h4ABA constant, default CNT_W.
REQ-033 One sub-module: the existing CRC_CAL core instanced as crc_cal, driven by CLK4, D, CRC_ARM, CRC_ENB.

Verification
REQ-034 RST, BURST_START, BURST_STOP, no words -> CRC_VALID pulse, CRC_OUT=16'h4ABA; HCRC_STB D=16'h4ABA -> CRC_ERR=0.
REQ-035 Burst of 4 words 16'h0001..16'h0004, last with BURST_STOP same cycle -> CRC_OUT equals golden model of 4 words, WORD_CNT=4 (macro on).
REQ-036 Same burst, HCRC_STB D=CRC_OUT^16'h0001 -> CRC_ERR=1, stays 1 until next BURST_START.
REQ-037 ABORT after 2 words -> IDLE next cycle, BUSY=0, no CRC_VALID, CRC_OUT unchanged.
REQ-038 WORD_STB in IDLE and CHECK, HCRC_STB in XFER -> no CRC change, no state change.
REQ-039 Macro on, 2^CNT_W+1 words (CNT_W=4: 17) -> WORD_CNT=1; macro off -> WORD_CNT=0 throughout.

Source files
------------

// File: rtl/udma_crc_seq_pkg.sv
// Shared definitions for the UDMA burst CRC sequencer.
//   - FSM state encoding
//   - CRC preset and generator polynomial (x^16 + x^12 + x^5 + 1)
//   - default burst word counter width
//   - one-word CRC update helper used by the CRC core
package udma_crc_seq_pkg;

    localparam int          CNT_W_DEF  = 16;
    localparam logic [15:0] CRC_PRESET = 16'h4ABA;
    localparam logic [15:0] CRC_POLY   = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER  = 3'd1,
        ST_TERM  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Advance the CRC by one 16-bit word, data bit 15 entering first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                               input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/udma_crc_seq_crc_cal.sv
// CRC_CAL core: 16-bit word-parallel CRC register.
// Ports:
//   CLK4     in   clock
//   D        in   16-bit data word
//   CRC_ARM  in   0: register held at preset, 1: register may accumulate
//   CRC_ENB  in   fold D into the register on this edge (only while armed)
//   CRC      out  current CRC register value
// The preset load through CRC_ARM doubles as the core's reset: the sequencer
// keeps CRC_ARM low while idle, including during its own reset.
module udma_crc_seq_crc_cal
    import udma_crc_seq_pkg::*;
(
    input  logic        CLK4,
    input  logic [15:0] D,
    input  logic        CRC_ARM,
    input  logic        CRC_ENB,
    output logic [15:0] CRC
);

    always_ff @(posedge CLK4) begin
        if (!CRC_ARM)
            CRC <= CRC_PRESET;
        else if (CRC_ENB)
            CRC <= crc16_word(CRC, D);
    end

endmodule

// File: rtl/udma_crc_seq.sv
// UDMA burst CRC sequencer.
// Accumulates a CRC over the words of one UDMA burst, latches it when the
// data phase ends, then compares it to the CRC word sent by the host.
// Optional build macro: UDMA_CRC_WORD_COUNT_EN enables the burst word
// counter; without it WORD_CNT is tied to zero.
// Ports:
//   CLK4         in   clock, all logic on rising edge
//   RST          in   synchronous active-high reset
//   BURST_START  in   pulse, burst begins (accepted only in IDLE)
//   BURST_STOP   in   pulse, data phase terminated
//   ABORT        in   pulse, cancel burst (wins over every other pulse)
//   WORD_STB     in   pulse, D carries a transferred word
//   HCRC_STB     in   pulse, D carries the host CRC word
//   D            in   16-bit data bus
//   BUSY         out  high in XFER, TERM, CHECK, DONE
//   CRC_OUT      out  CRC latched at burst termination
//   CRC_VALID    out  one-cycle pulse when CRC_OUT updates
//   CRC_ERR      out  sticky host/device CRC mismatch
//   WORD_CNT     out  words accumulated in the current burst
//
// state | meaning
// IDLE  | CRC core held at preset, waiting for BURST_START
// XFER  | data phase, each WORD_STB folds D into the CRC
// TERM  | data phase over, CRC latched into CRC_OUT on exit
// CHECK | waiting for host CRC word
// DONE  | compare done, back to IDLE next cycle
module udma_crc_seq
    import udma_crc_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK4,
    input  logic             RST,
    input  logic             BURST_START,
    input  logic             BURST_STOP,
    input  logic             ABORT,
    input  logic             WORD_STB,
    input  logic             HCRC_STB,
    input  logic [15:0]      D,
    output logic             BUSY,
    output logic [15:0]      CRC_OUT,
    output logic             CRC_VALID,
    output logic             CRC_ERR,
    output logic [CNT_W-1:0] WORD_CNT
);

    seq_state_t  state, state_nxt;
    logic        crc_arm;
    logic        crc_enb;
    logic [15:0] crc_cur;
    logic        start_acc;
    logic        word_acc;
    logic        latch_crc;
    logic        hcrc_acc;

    // ABORT beats every simultaneous pulse, including a start in IDLE.
    assign start_acc = (state == ST_IDLE)  && BURST_START && !ABORT;
    assign word_acc  = (state == ST_XFER)  && WORD_STB    && !ABORT;
    assign latch_crc = (state == ST_TERM)  && !ABORT;
    assign hcrc_acc  = (state == ST_CHECK) && HCRC_STB    && !ABORT;

    assign crc_arm = (state != ST_IDLE);
    assign crc_enb = word_acc;
    assign BUSY    = (state != ST_IDLE);

    always_ff @(posedge CLK4) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_acc)
                    state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (ABORT)
                    state_nxt = ST_IDLE;
                else if (BURST_STOP)
                    state_nxt = ST_TERM;
            end
            ST_TERM: begin
                state_nxt = ABORT ? ST_IDLE : ST_CHECK;
            end
            ST_CHECK: begin
                if (ABORT)
                    state_nxt = ST_IDLE;
                else if (HCRC_STB)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    udma_crc_seq_crc_cal crc_cal (
        .CLK4    (CLK4),
        .D       (D),
        .CRC_ARM (crc_arm),
        .CRC_ENB (crc_enb),
        .CRC     (crc_cur)
    );

    // CRC_OUT and CRC_VALID update on the same edge, so the pulse lands on
    // the first CHECK cycle. The compare in CHECK uses the latched CRC_OUT.
    always_ff @(posedge CLK4) begin
        if (RST) begin
            CRC_OUT   <= 16'h0000;
            CRC_VALID <= 1'b0;
            CRC_ERR   <= 1'b0;
        end else begin
            CRC_VALID <= latch_crc;
            if (latch_crc)
                CRC_OUT <= crc_cur;
            if (start_acc)
                CRC_ERR <= 1'b0;
            else if (hcrc_acc)
                CRC_ERR <= CRC_ERR | (D != CRC_OUT);
        end
    end

`ifdef UDMA_CRC_WORD_COUNT_EN
    logic [CNT_W-1:0] word_cnt_q;

    // Free-running wrap; counting stops naturally once XFER is left.
    always_ff @(posedge CLK4) begin
        if (RST)
            word_cnt_q <= '0;
        else if (start_acc)
            word_cnt_q <= '0;
        else if (word_acc)
            word_cnt_q <= word_cnt_q + 1'b1;
    end

    assign WORD_CNT = word_cnt_q;
`else
    assign WORD_CNT = '0;
`endif

endmodule

// File: tb/tb_udma_crc_seq.sv
// Self-checking bench for udma_crc_seq (counter width 4 so wrap is cheap).
module tb_udma_crc_seq;

    localparam int CW = 4;
`ifdef UDMA_CRC_WORD_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          CLK4 = 1'b0;
    logic          RST, BURST_START, BURST_STOP, ABORT, WORD_STB, HCRC_STB;
    logic [15:0]   D;
    logic          BUSY, CRC_VALID, CRC_ERR;
    logic [15:0]   CRC_OUT;
    logic [CW-1:0] WORD_CNT;

    int checks   = 0;
    int failures = 0;
    logic [15:0] burst_q[$];

    always #5 CLK4 = ~CLK4;

    udma_crc_seq #(.CNT_W(CW)) dut (
        .CLK4(CLK4), .RST(RST), .BURST_START(BURST_START), .BURST_STOP(BURST_STOP),
        .ABORT(ABORT), .WORD_STB(WORD_STB), .HCRC_STB(HCRC_STB), .D(D),
        .BUSY(BUSY), .CRC_OUT(CRC_OUT), .CRC_VALID(CRC_VALID), .CRC_ERR(CRC_ERR),
        .WORD_CNT(WORD_CNT)
    );

    // CRC as a polynomial remainder: (M(x)*x^16 + S(x)*x^N) mod G(x), done as
    // long division over an explicit bit array. The seed is folded into the
    // first 16 message bits.
    function automatic logic [15:0] crc_model();
        bit          bits[$];
        logic [16:0] g;
        logic [15:0] s;
        logic [15:0] w;
        logic [15:0] r;
        int          n;
        g = 17'h11021;
        s = 16'h4ABA;
        if (burst_q.size() == 0) return s;
        foreach (burst_q[k]) begin
            w = burst_q[k];
            for (int b = 15; b >= 0; b--) bits.push_back(w[b]);
        end
        n = bits.size();
        for (int k = 0; k < 16; k++) bits[k] = bits[k] ^ s[15-k];
        for (int k = 0; k < 16; k++) bits.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (bits[i])
                for (int k = 0; k <= 16; k++) bits[i+k] = bits[i+k] ^ g[16-k];
        for (int k = 0; k < 16; k++) r[15-k] = bits[n+k];
        return r;
    endfunction

    function automatic logic [CW-1:0] exp_cnt(input int n);
        if (CNT_ON) return CW'(n % (1 << CW));
        return '0;
    endfunction

    // Apply one cycle of pulses, then sample 1 time unit after the edge.
    task automatic step(input logic bs, input logic bp, input logic ab,
                        input logic ws, input logic hs, input logic [15:0] d);
        BURST_START = bs; BURST_STOP = bp; ABORT = ab;
        WORD_STB = ws; HCRC_STB = hs; D = d;
        @(posedge CLK4);
        #1;
        BURST_START = 1'b0; BURST_STOP = 1'b0; ABORT = 1'b0;
        WORD_STB = 1'b0; HCRC_STB = 1'b0; D = 16'h0000;
    endtask

    // Drives one complete burst from burst_q and reports what it saw.
    task automatic do_burst(input bit stop_last, input logic [15:0] hd,
                            output logic [15:0] crc_seen, output int vcnt,
                            output bit ok);
        int n;
        n = burst_q.size();
        ok = 1'b1; vcnt = 0; crc_seen = 16'h0000;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        if (BUSY !== 1'b1) ok = 1'b0;
        vcnt += int'(CRC_VALID);
        for (int i = 0; i < n; i++) begin
            step(1'b0, stop_last && (i == n-1), 1'b0, 1'b1, 1'b0, burst_q[i]);
            if (BUSY !== 1'b1) ok = 1'b0;
            vcnt += int'(CRC_VALID);
        end
        if (!stop_last || n == 0) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
            vcnt += int'(CRC_VALID);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        if (CRC_VALID !== 1'b1) ok = 1'b0;
        crc_seen = CRC_OUT;
        vcnt += int'(CRC_VALID);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hd);
        if (BUSY !== 1'b1) ok = 1'b0;
        vcnt += int'(CRC_VALID);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        if (BUSY !== 1'b0) ok = 1'b0;
        vcnt += int'(CRC_VALID);
    endtask

    logic [15:0] last_crc;

    task automatic test_reset();
        RST = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        RST = 1'b0;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (CRC_OUT !== 16'h0000) begin failures++; $display("FAIL reset_crc_out got=%h exp=0000", CRC_OUT); end
        checks++; if (CRC_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", CRC_VALID); end
        checks++; if (CRC_ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", CRC_ERR); end
        checks++; if (WORD_CNT !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", WORD_CNT); end
    endtask

    task automatic test_zero_burst();
        logic [15:0] c; int v; bit ok;
        burst_q.delete();
        do_burst(1'b0, 16'h4ABA, c, v, ok);
        checks++; if (c !== 16'h4ABA) begin failures++; $display("FAIL zero_crc got=%h exp=4aba", c); end
        checks++; if (v !== 1) begin failures++; $display("FAIL zero_valid_cnt got=%0d exp=1", v); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL zero_seq got=%b exp=1", ok); end
        checks++; if (CRC_ERR !== 1'b0) begin failures++; $display("FAIL zero_err got=%b exp=0", CRC_ERR); end
        checks++; if (CRC_OUT !== 16'h4ABA) begin failures++; $display("FAIL zero_crc_hold got=%h exp=4aba", CRC_OUT); end
        last_crc = 16'h4ABA;
    endtask

    task automatic test_four_words();
        logic [15:0] c, e; int v; bit ok;
        burst_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        e = crc_model();
        do_burst(1'b1, e, c, v, ok);
        checks++; if (c !== e) begin failures++; $display("FAIL four_crc got=%h exp=%h", c, e); end
        checks++; if (v !== 1 || ok !== 1'b1) begin failures++; $display("FAIL four_seq valid_cnt=%0d ok=%b exp 1/1", v, ok); end
        checks++; if (CRC_ERR !== 1'b0) begin failures++; $display("FAIL four_err got=%b exp=0", CRC_ERR); end
        checks++; if (WORD_CNT !== exp_cnt(4)) begin failures++; $display("FAIL four_cnt got=%0d exp=%0d", WORD_CNT, exp_cnt(4)); end
        last_crc = e;
    endtask

    task automatic test_crc_err();
        logic [15:0] c, e; int v; bit ok;
        burst_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        e = crc_model();
        do_burst(1'b1, e ^ 16'h0001, c, v, ok);
        checks++; if (c !== e) begin failures++; $display("FAIL err_crc got=%h exp=%h", c, e); end
        checks++; if (CRC_ERR !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", CRC_ERR); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, e);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (CRC_ERR !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", CRC_ERR); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (CRC_ERR !== 1'b0) begin failures++; $display("FAIL err_clear_on_start got=%b exp=0", CRC_ERR); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        checks++; if (CRC_OUT !== e) begin failures++; $display("FAIL err_crc_hold got=%h exp=%h", CRC_OUT, e); end
        last_crc = e;
    endtask

    task automatic test_abort();
        int v;
        v = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'($urandom));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'($urandom));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_xfer_busy got=%b exp=0", BUSY); end
        v += int'(CRC_VALID);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        v += int'(CRC_VALID);
        // Abort together with stop and a word: abort must win.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_with_stop_busy got=%b exp=0", BUSY); end
        v += int'(CRC_VALID);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        v += int'(CRC_VALID);
        // Abort while in TERM.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_term_busy got=%b exp=0", BUSY); end
        v += int'(CRC_VALID);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        v += int'(CRC_VALID);
        checks++; if (v !== 0) begin failures++; $display("FAIL abort_valid_pulses got=%0d exp=0", v); end
        checks++; if (CRC_OUT !== last_crc) begin failures++; $display("FAIL abort_crc_hold got=%h exp=%h", CRC_OUT, last_crc); end
        // Abort in CHECK beats a mismatching host CRC.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        last_crc = 16'h4ABA;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
        checks++; if (BUSY !== 1'b0 || CRC_ERR !== 1'b0) begin failures++; $display("FAIL abort_check busy=%b err=%b exp 0/0", BUSY, CRC_ERR); end
        checks++; if (CRC_OUT !== last_crc) begin failures++; $display("FAIL abort_check_crc got=%h exp=%h", CRC_OUT, last_crc); end
    endtask

    task automatic test_ignored();
        logic [15:0] a, b, e;
        a = 16'($urandom); b = 16'($urandom);
        burst_q = '{a, b};
        e = crc_model();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL ign_idle_busy got=%b exp=0", BUSY); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hF00D);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL ign_hcrc_in_xfer busy=%b exp=1", BUSY); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, b);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (CRC_VALID !== 1'b1 || CRC_OUT !== e) begin failures++; $display("FAIL ign_crc valid=%b got=%h exp=%h", CRC_VALID, CRC_OUT, e); end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA5A5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
        checks++; if (BUSY !== 1'b1 || CRC_OUT !== e) begin failures++; $display("FAIL ign_check busy=%b crc=%h exp 1/%h", BUSY, CRC_OUT, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (BUSY !== 1'b0 || CRC_ERR !== 1'b0) begin failures++; $display("FAIL ign_done busy=%b err=%b exp 0/0", BUSY, CRC_ERR); end
        checks++; if (WORD_CNT !== exp_cnt(2)) begin failures++; $display("FAIL ign_cnt got=%0d exp=%0d", WORD_CNT, exp_cnt(2)); end
        last_crc = e;
    endtask

    task automatic test_wrap();
        logic [15:0] c, e; int v; bit ok;
        burst_q.delete();
        for (int i = 0; i < 17; i++) burst_q.push_back(16'($urandom));
        e = crc_model();
        do_burst(1'b1, e, c, v, ok);
        checks++; if (c !== e) begin failures++; $display("FAIL wrap_crc got=%h exp=%h", c, e); end
        checks++; if (WORD_CNT !== exp_cnt(17)) begin failures++; $display("FAIL wrap_cnt got=%0d exp=%0d", WORD_CNT, exp_cnt(17)); end
        last_crc = e;
    endtask

    task automatic test_random();
        logic [15:0] c, e, hd; int v, n; bit ok, sl, bad;
        for (int it = 0; it < 25; it++) begin
            n = int'($urandom_range(0, 20));
            burst_q.delete();
            for (int i = 0; i < n; i++) burst_q.push_back(16'($urandom));
            sl  = 1'($urandom_range(0, 1));
            bad = 1'($urandom_range(0, 1));
            e = crc_model();
            hd = bad ? (e ^ (16'h0001 << $urandom_range(0, 15))) : e;
            do_burst(sl, hd, c, v, ok);
            checks++; if (c !== e) begin failures++; $display("FAIL rand_crc it=%0d n=%0d got=%h exp=%h", it, n, c, e); end
            checks++; if (v !== 1 || ok !== 1'b1) begin failures++; $display("FAIL rand_seq it=%0d valid_cnt=%0d ok=%b exp 1/1", it, v, ok); end
            checks++; if (CRC_ERR !== bad) begin failures++; $display("FAIL rand_err it=%0d got=%b exp=%b", it, CRC_ERR, bad); end
            checks++; if (WORD_CNT !== exp_cnt(n)) begin failures++; $display("FAIL rand_cnt it=%0d got=%0d exp=%0d", it, WORD_CNT, exp_cnt(n)); end
            last_crc = e;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] c; int v; bit ok;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1111);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h2222);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        RST = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0BAD);
        RST = 1'b0;
        checks++; if (BUSY !== 1'b0 || CRC_VALID !== 1'b0) begin failures++; $display("FAIL rstmid_busy_valid got=%b/%b exp 0/0", BUSY, CRC_VALID); end
        checks++; if (CRC_OUT !== 16'h0000 || CRC_ERR !== 1'b0) begin failures++; $display("FAIL rstmid_out crc=%h err=%b exp 0000/0", CRC_OUT, CRC_ERR); end
        checks++; if (WORD_CNT !== '0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", WORD_CNT); end
        burst_q.delete();
        do_burst(1'b0, 16'h4ABA, c, v, ok);
        checks++; if (c !== 16'h4ABA || v !== 1) begin failures++; $display("FAIL rstmid_after crc=%h valid_cnt=%0d exp 4aba/1", c, v); end
    endtask

    initial begin
        RST = 1'b1; BURST_START = 1'b0; BURST_STOP = 1'b0; ABORT = 1'b0;
        WORD_STB = 1'b0; HCRC_STB = 1'b0; D = 16'h0000;
        last_crc = 16'h0000;
        test_reset();
        test_zero_burst();
        test_four_words();
        test_crc_err();
        test_abort();
        test_ignored();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
